imm_alu_pipe: RTL and testbench
===============================

# imm_alu_pipe

Parametrised, two-stage pipelined immediate ALU for the TSC datapath. It extends an I-type immediate to the datapath width, then computes ADI/ORI/LHI results with a zero flag and an illegal-opcode flag. Operands and opcode enter through a valid/ready handshake; results leave through a second valid/ready handshake. The block sits between the register-read stage and writeback, and its flow control lets the multi-cycle control unit stall it without losing operations.

## Interface
- `WIDTH`, 16: datapath width; must be even and at least 2×`IMM_W`.
- `IMM_W`, 8: immediate field width.
- `OPC_W`, 4: opcode width.
- `TAG_W`, 2: width of the opaque tag carried alongside each operation.
- `clk` input 1: clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_valid` input 1: upstream offers an operation.
- `in_ready` output 1: block accepts the operation this cycle.
- `in_opcode` input `OPC_W`: ADI_OP, ORI_OP or LHI_OP, from `opcodes.v`.
- `in_reg` input `WIDTH`: register operand (rs).
- `in_imm` input `IMM_W`: raw immediate field.
- `in_tag` input `TAG_W`: tag, returned unchanged with the result.
- `out_valid` output 1: a result is presented.
- `out_ready` input 1: downstream consumes the result.
- `out_data` output `WIDTH`: the result.
- `out_zero` output 1: asserted when `out_data` is 0.
- `out_illegal` output 1: the opcode was not ADI, ORI or LHI.
- `out_tag` output `TAG_W`: tag of this result.

## Operation
- Stage 1 (S1) registers the opcode, `in_reg` and the extended immediate `ext`, plus `v1`.
  - ADI: `ext` is `in_imm` sign-extended.
  - ORI: `ext` is `in_imm` zero-extended.
  - LHI: `ext` is `in_imm` placed at bits [WIDTH-1 : WIDTH-IMM_W], with zeros below.
  - Any other opcode: `ext` is 0.
- Stage 2 (S2) registers the result, flags and tag, plus `v2`. The S2 registers drive the `out_*` outputs.
  - ADI: `reg + ext`, modulo 2^WIDTH (carry dropped).
  - ORI: `reg | ext`.
  - LHI: `ext`; the register operand is ignored.
  - Any other opcode: the result is `reg` and `out_illegal` is 1.
- Flow control:
  - Transfers happen only on `valid && ready` in the same cycle.
  - `adv2 = !v2 || out_ready`.
  - `adv1 = !v1 || adv2`.
  - `in_ready = adv1`. It is a combinational function of `v1`, `v2` and `out_ready`, never of `in_valid`.
  - When `adv2` is high, S2 loads S1's contents: `v2 <= v1`.
  - When `adv1` is high, S1 loads the input: `v1 <= in_valid`.
  - While stalled, S1 and S2 hold their contents, so `out_*` stays stable while `out_valid && !out_ready`.
- Simultaneous events: the pipeline can be full while downstream consumes and upstream presents in the same cycle. The pipeline then shifts by one with no bubble, giving one result per cycle sustained.
- Data registers with `v == 0` are don't-care, but they must not change `out_*` while `out_valid` is 0.

## Timing
- Latency: 2 cycles. An operation accepted at edge N has `out_valid` = 1 after edge N+1.
- Throughput: 1 operation per cycle while `out_ready` = 1.
- Reset takes effect at the next edge. It clears `v1` and `v2`, clears `out_data`, `out_zero`, `out_illegal` and `out_tag` to 0, and clears `out_ovf` when present.
  - After reset, `out_valid` = 0 and `in_ready` = 1.
  - Reset mid-operation discards all in-flight operations.
  - An input presented in the same cycle as reset is not accepted.
- Capacity: 2 operations. With `out_ready` held low, exactly two accepts occur, then `in_ready` = 0.

## Configuration
- `IMM_ALU_OVF_EN` defined:
  - Adds an output port `out_ovf` (1 bit), registered in S2.
  - For ADI, `out_ovf` = signed overflow: both operand signs are equal and the result sign differs.
  - For all other opcodes, `out_ovf` = 0.
- `IMM_ALU_OVF_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `imm_alu_pkg`:
  - Opcode constants, mirrored from `opcodes.v`.
  - The `ext_kind_t` enum: SIGN, ZERO, HIGH.
  - The function that maps an opcode to its `ext_kind_t`.
- Sub-module `imm_alu_core`: purely combinational. It takes opcode, reg and ext, and returns result, illegal flag and overflow. It is instanced between S1 and S2.

## Test plan
- ADI, reg = 0x0005, imm = 0xFF → 0x0004, zero = 0. If `IMM_ALU_OVF_EN`: ADI, reg = 0x7FFF, imm = 0x01 → 0x8000, ovf = 1.
- ORI, reg = 0x1200, imm = 0x80 → 0x1280 (zero-extended). LHI, reg = 0xABCD, imm = 0x3C → 0x3C00.
- ADI, reg = 0x0001, imm = 0xFF → 0x0000, `out_zero` = 1. Undefined opcode, reg = 0x5A5A → `out_data` = 0x5A5A, `out_illegal` = 1.
- Back-to-back stream of 8 operations with `out_ready` = 1 → 8 results in order, tags matching, consecutive cycles, first result 2 cycles after the first accept.
- `out_ready` low for 5 cycles while `in_valid` is held high → exactly 2 accepts, then `in_ready` = 0 and `out_*` stable. On release, results drain in order with none lost or duplicated.
- Reset asserted while both stages are valid → after the edge, `out_valid` = 0 and `in_ready` = 1. No stale result appears afterwards.

Source files
------------

// File: rtl/imm_alu_pkg.sv
// imm_alu_pkg: opcode constants and immediate-extension kind shared by the immediate ALU.
package imm_alu_pkg;
  localparam int ADI_OP = 1;
  localparam int ORI_OP = 2;
  localparam int LHI_OP = 3;
  typedef enum logic [1:0] {SIGN, ZERO, HIGH, NONE} ext_kind_t;
  function automatic ext_kind_t ext_kind_of(int unsigned opc);
    return opc == ADI_OP ? SIGN : opc == ORI_OP ? ZERO : opc == LHI_OP ? HIGH : NONE;
  endfunction
endpackage

// File: rtl/imm_alu_if.sv
// imm_alu_if: operand and result valid/ready handshakes of the immediate ALU; out_ovf exists only with IMM_ALU_OVF_EN.
interface imm_alu_if #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 8,
  parameter int OPC_W = 4,
  parameter int TAG_W = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [OPC_W-1:0] in_opcode;
  logic [WIDTH-1:0] in_reg;
  logic [IMM_W-1:0] in_imm;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;
`ifdef IMM_ALU_OVF_EN
  logic             out_ovf;
`endif
  modport slave (
    input  in_valid, in_opcode, in_reg, in_imm, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_illegal, out_tag
`ifdef IMM_ALU_OVF_EN
    , output out_ovf
`endif
  );
  modport master (
    output in_valid, in_opcode, in_reg, in_imm, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_illegal, out_tag
`ifdef IMM_ALU_OVF_EN
    , input out_ovf
`endif
  );
endinterface

// File: rtl/imm_alu_core.sv
// imm_alu_core: combinational ADI/ORI/LHI evaluation on an already-extended immediate.
module imm_alu_core
  import imm_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPC_W = 4
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] ext,
  output logic [WIDTH-1:0] result,
  output logic             illegal
`ifdef IMM_ALU_OVF_EN
  , output logic           ovf
`endif
);
  ext_kind_t        kind;
  logic [WIDTH-1:0] sum;
  assign kind    = ext_kind_of(32'(opcode));
  assign sum     = rs + ext;
  assign result  = kind == SIGN ? sum : kind == ZERO ? rs | ext : kind == HIGH ? ext : rs;
  assign illegal = kind == NONE;
`ifdef IMM_ALU_OVF_EN
  assign ovf     = kind == SIGN && rs[WIDTH-1] == ext[WIDTH-1] && sum[WIDTH-1] != rs[WIDTH-1];
`endif
endmodule

// File: rtl/imm_alu_pipe.sv
// imm_alu_pipe: two-stage immediate ALU (extend, then compute) with valid/ready flow control.
// Define IMM_ALU_OVF_EN to add the registered signed-overflow output out_ovf.
module imm_alu_pipe
  import imm_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IMM_W = 8,
  parameter int OPC_W = 4,
  parameter int TAG_W = 2
) (
  input logic        clk,
  input logic        reset,
  imm_alu_if.slave   bus
);
  logic             v1, v2, adv1, adv2, ill;
  logic [OPC_W-1:0] op1;
  logic [WIDTH-1:0] rs1, ext1, ext, res;
  logic [TAG_W-1:0] tag1;
  ext_kind_t        kind;
`ifdef IMM_ALU_OVF_EN
  logic             ovf;
`endif
  assign adv2          = !v2 || bus.out_ready;
  assign adv1          = !v1 || adv2;
  assign bus.in_ready  = adv1;
  assign bus.out_valid = v2;
  assign kind          = ext_kind_of(32'(bus.in_opcode));
  assign ext = kind == SIGN ? {{(WIDTH-IMM_W){bus.in_imm[IMM_W-1]}}, bus.in_imm} :
               kind == ZERO ? WIDTH'(bus.in_imm) :
               kind == HIGH ? {bus.in_imm, {(WIDTH-IMM_W){1'b0}}} : '0;
  imm_alu_core #(.WIDTH(WIDTH), .OPC_W(OPC_W)) core (
    .opcode (op1),
    .rs     (rs1),
    .ext    (ext1),
    .result (res),
    .illegal(ill)
`ifdef IMM_ALU_OVF_EN
    , .ovf  (ovf)
`endif
  );
  // Data registers load only with a valid operation so out_* never moves while out_valid is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1              <= 1'b0;
      v2              <= 1'b0;
      bus.out_data    <= '0;
      bus.out_zero    <= 1'b0;
      bus.out_illegal <= 1'b0;
      bus.out_tag     <= '0;
`ifdef IMM_ALU_OVF_EN
      bus.out_ovf     <= 1'b0;
`endif
    end else begin
      if (adv2) v2 <= v1;
      if (adv1) v1 <= bus.in_valid;
      if (adv1 && bus.in_valid) begin
        op1  <= bus.in_opcode;
        rs1  <= bus.in_reg;
        ext1 <= ext;
        tag1 <= bus.in_tag;
      end
      if (adv2 && v1) begin
        bus.out_data    <= res;
        bus.out_zero    <= res == '0;
        bus.out_illegal <= ill;
        bus.out_tag     <= tag1;
`ifdef IMM_ALU_OVF_EN
        bus.out_ovf     <= ovf;
`endif
      end
    end
  end
endmodule

// File: tb/tb_imm_alu_pipe.sv
// tb_imm_alu_pipe: directed and random traffic against a queue-based reference of the immediate ALU.
module tb_imm_alu_pipe;
  import imm_alu_pkg::*;
  typedef struct {
    logic [15:0] d;
    logic        z, il, ov;
    logic [1:0]  t;
    int          acc;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  imm_alu_if bus ();
  imm_alu_pipe dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  exp_t q[$];
  exp_t last;
  int   cyc = 1;
  int   n_vec = 0;
  int   n_err = 0;
  bit   accepted;

  function automatic exp_t model(int op, int rg, int im, int tg);
    exp_t m;
    int   simm, s;
    m    = '{default: 0};
    m.t  = 2'(tg);
    simm = im >= 128 ? im - 256 : im;
    s    = (rg >= 32768 ? rg - 65536 : rg) + simm;
    if (op == ADI_OP) begin
      m.d  = 16'(rg + simm);
      m.ov = s > 32767 || s < -32768;
    end else if (op == ORI_OP) m.d = 16'(rg | im);
    else if (op == LHI_OP) m.d = 16'(im * 256);
    else begin
      m.d  = 16'(rg);
      m.il = 1'b1;
    end
    m.z = m.d == 16'h0;
    return m;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // One clock: check outputs from the last edge, drive the next inputs, then advance the reference.
  task automatic step(bit iv, int op, int rg, int im, int tg, bit ordy, bit rst);
    bit   ev, er;
    exp_t e;
    @(negedge clk);
    ev = q.size() > 0 && q[0].acc < cyc;
    e  = ev ? q[0] : last;
    chk("out_valid", 32'(bus.out_valid), 32'(ev));
    chk("out_data", 32'(bus.out_data), 32'(e.d));
    chk("out_zero", 32'(bus.out_zero), 32'(e.z));
    chk("out_illegal", 32'(bus.out_illegal), 32'(e.il));
    chk("out_tag", 32'(bus.out_tag), 32'(e.t));
`ifdef IMM_ALU_OVF_EN
    chk("out_ovf", 32'(bus.out_ovf), 32'(e.ov));
`endif
    bus.in_valid  = iv;
    bus.in_opcode = 4'(op);
    bus.in_reg    = 16'(rg);
    bus.in_imm    = 8'(im);
    bus.in_tag    = 2'(tg);
    bus.out_ready = ordy;
    reset         = rst;
    #1;
    er = q.size() < 2 || ordy;
    chk("in_ready", 32'(bus.in_ready), 32'(er));
    accepted = iv && bus.in_ready && !rst;
    if (rst) begin
      q.delete();
      last = '{default: 0};
    end else begin
      if (ev && ordy) last = q.pop_front();
      if (iv && er) begin
        e     = model(op, rg, im, tg);
        e.acc = cyc + 1;
        q.push_back(e);
      end
    end
    cyc++;
  endtask

  initial begin
    exp_t m;
    int   acc_cnt, r, op;
    bus.in_valid  = 1'b0;
    bus.in_opcode = '0;
    bus.in_reg    = '0;
    bus.in_imm    = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
    last          = '{default: 0};
    m = model(ADI_OP, 'h0005, 'hFF, 0);
    chk("pin_adi_data", 32'(m.d), 32'h0004);
    chk("pin_adi_zero", 32'(m.z), 32'h0);
    m = model(ADI_OP, 'h7FFF, 'h01, 0);
    chk("pin_adi_ovf_data", 32'(m.d), 32'h8000);
    chk("pin_adi_ovf", 32'(m.ov), 32'h1);
    m = model(ORI_OP, 'h1200, 'h80, 0);
    chk("pin_ori", 32'(m.d), 32'h1280);
    m = model(LHI_OP, 'hABCD, 'h3C, 0);
    chk("pin_lhi", 32'(m.d), 32'h3C00);
    m = model(ADI_OP, 'h0001, 'hFF, 0);
    chk("pin_adi_zero_flag", 32'(m.z), 32'h1);
    m = model(15, 'h5A5A, 'h12, 0);
    chk("pin_illegal", 32'(m.d) | (32'(m.il) << 16), 32'h15A5A);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 0);
    step(1, ADI_OP, 'h0005, 'hFF, 0, 1, 0);
    step(1, ADI_OP, 'h7FFF, 'h01, 1, 1, 0);
    step(1, ORI_OP, 'h1200, 'h80, 2, 1, 0);
    step(1, LHI_OP, 'hABCD, 'h3C, 3, 1, 0);
    step(1, ADI_OP, 'h0001, 'hFF, 0, 1, 0);
    step(1, 15, 'h5A5A, 'h00, 1, 1, 0);
    for (int i = 0; i < 8; i++) step(1, i % 3 + 1, 'h1111 * i, 16 * i + 3, i, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 0);
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, ADI_OP, 'h0100 + i, i, i, 0, 0);
      acc_cnt += int'(accepted);
    end
    chk("capacity_accepts", 32'(acc_cnt), 32'd2);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, ORI_OP, 'h0F00, 'h55 + i, i, 0, 0);
    step(1, LHI_OP, 'h1234, 'h77, 3, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("post_reset_valid", 32'(bus.out_valid), 32'h0);
    chk("post_reset_ready", 32'(bus.in_ready), 32'h1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 400; i++) begin
      r  = int'($urandom_range(0, 3));
      op = r == 3 ? int'($urandom_range(0, 15)) : r + 1;
      step($urandom_range(0, 9) < 7, op, int'($urandom_range(0, 65535)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 3)), $urandom_range(0, 9) < 7, $urandom_range(0, 99) == 0);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
